// File: rtl/simd_vec_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : simd_vec_pipeline
//  Brief    : 3-stage (Issue/Execute/Writeback) SIMD vector core with a
//             REG_CNT x LANES x LANE_W register file, valid/ready issue,
//             RAW interlock, synchronous flush and a saturating stall counter.
//  Options  : define SIMD_VEC_FWD_EN to forward the E-stage result to the
//             issue operands and remove the hazard stall.
//  Revision : 1.0  initial release
// ============================================================================
module simd_vec_pipeline #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 16,
  parameter int REG_CNT  = 16,
  parameter int SEL_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [SEL_BITS-1:0]       in_rd,
  input  logic [SEL_BITS-1:0]       in_rs1,
  input  logic [SEL_BITS-1:0]       in_rs2,
  input  logic [LANE_W-1:0]         in_imm,
  input  logic                      flush,
  output logic                      wb_valid,
  output logic [SEL_BITS-1:0]       wb_rd,
  output logic [LANES*LANE_W-1:0]   wb_data,
  output logic                      illegal,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int DW   = LANES * LANE_W;
  localparam int SH_W = $clog2(LANE_W);

  localparam logic [3:0] OP_VADD  = 4'd1;
  localparam logic [3:0] OP_VSUB  = 4'd2;
  localparam logic [3:0] OP_VMUL  = 4'd3;
  localparam logic [3:0] OP_VAND  = 4'd4;
  localparam logic [3:0] OP_VOR   = 4'd5;
  localparam logic [3:0] OP_VXOR  = 4'd6;
  localparam logic [3:0] OP_VSHL  = 4'd7;
  localparam logic [3:0] OP_VSHR  = 4'd8;
  localparam logic [3:0] OP_VLDI  = 4'd9;
  localparam logic [3:0] OP_VADDI = 4'd10;

  function automatic logic uses_rs1(input logic [3:0] op);
    return ((op >= OP_VADD) && (op <= OP_VSHR)) || (op == OP_VADDI);
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op >= OP_VADD) && (op <= OP_VXOR);
  endfunction

  // NOP and the undefined opcodes never update the register file
  function automatic logic writes_rf(input logic [3:0] op);
    return (op >= OP_VADD) && (op <= OP_VADDI);
  endfunction

  logic [DW-1:0]       rf [REG_CNT];

  logic                e_valid;
  logic                e_we;
  logic [3:0]          e_op;
  logic [SEL_BITS-1:0] e_rd;
  logic [DW-1:0]       e_a;
  logic [DW-1:0]       e_b;
  logic [LANE_W-1:0]   e_imm;
  logic [DW-1:0]       e_result;

  logic                w_we;
  logic [DW-1:0]       op_a;
  logic [DW-1:0]       op_b;
  logic                hazard;
  logic                accept;

  // Operand read: register file, overridden by W write-through, then E forward
  always_comb begin
    op_a = rf[in_rs1];
    op_b = rf[in_rs2];
    if (wb_valid && w_we && (wb_rd == in_rs1)) op_a = wb_data;
    if (wb_valid && w_we && (wb_rd == in_rs2)) op_b = wb_data;
`ifdef SIMD_VEC_FWD_EN
    if (e_valid && e_we && (e_rd == in_rs1)) op_a = e_result;
    if (e_valid && e_we && (e_rd == in_rs2)) op_b = e_result;
`endif
  end

`ifdef SIMD_VEC_FWD_EN
  assign hazard = 1'b0;
`else
  // Only E can conflict: W is covered by write-through
  assign hazard = e_valid && e_we &&
                  ((uses_rs1(in_op) && (e_rd == in_rs1)) ||
                   (uses_rs2(in_op) && (e_rd == in_rs2)));
`endif

  assign in_ready = rst && !hazard;
  assign accept   = in_valid && in_ready;

  // Lane-wise execute ALU; NOP and undefined opcodes yield zero
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
    logic [LANE_W-1:0] r;
    assign a = e_a[i*LANE_W +: LANE_W];
    assign b = e_b[i*LANE_W +: LANE_W];

    // Per-lane operation select
    always_comb begin
      r = '0;
      case (e_op)
        OP_VADD:  r = a + b;
        OP_VSUB:  r = a - b;
        OP_VMUL:  r = a * b;
        OP_VAND:  r = a & b;
        OP_VOR:   r = a | b;
        OP_VXOR:  r = a ^ b;
        OP_VSHL:  r = a << e_imm[SH_W-1:0];
        OP_VSHR:  r = a >> e_imm[SH_W-1:0];
        OP_VLDI:  r = e_imm;
        OP_VADDI: r = a + e_imm;
        default:  r = '0;
      endcase
    end

    assign e_result[i*LANE_W +: LANE_W] = r;
  end

  // Issue -> Execute register; flush drops both E and any same-cycle accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid <= 1'b0;
      e_we    <= 1'b0;
      e_op    <= '0;
      e_rd    <= '0;
      e_a     <= '0;
      e_b     <= '0;
      e_imm   <= '0;
    end else begin
      e_valid <= accept && !flush;
      e_we    <= accept && !flush && writes_rf(in_op);
      if (accept) begin
        e_op  <= in_op;
        e_rd  <= in_rd;
        e_a   <= op_a;
        e_b   <= op_b;
        e_imm <= in_imm;
      end
    end
  end

  // Execute -> Writeback register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      w_we     <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= e_valid && !flush;
      w_we     <= e_valid && e_we && !flush;
      wb_rd    <= e_rd;
      wb_data  <= e_result;
    end
  end

  // Register file write from W; a flush at this edge suppresses it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < REG_CNT; k++) rf[k] <= '0;
    end else if (wb_valid && w_we && !flush) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Sticky undefined-opcode flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal <= 1'b0;
    end else if (accept && !flush && (in_op > OP_VADDI)) begin
      illegal <= 1'b1;
    end
  end

  // Saturating count of cycles where a request was held off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simd_vec_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_vec_pipeline
//  Brief    : Directed self-checking bench for simd_vec_pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simd_vec_pipeline;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [3:0]    in_rd;
  logic [3:0]    in_rs1;
  logic [3:0]    in_rs2;
  logic [15:0]   in_imm;
  logic          flush;
  logic          wb_valid;
  logic [3:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          illegal;
  logic [15:0]   stall_cnt;

  int errors = 0;
  int checks = 0;

  simd_vec_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .illegal   (illegal),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Present one instruction and hold it until accepted (bounded)
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%0d in_ready=%b required 1", op, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issue and capture what appears in W one cycle after acceptance
  task automatic exec(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm,
                      output logic vld, output logic [3:0] rdo, output logic [DW-1:0] data);
    send(op, rd, rs1, rs2, imm);
    @(posedge clk); #1;
    vld = wb_valid; rdo = wb_rd; data = wb_data;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b0 || wb_data !== '0 || illegal !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b wbv=%b data=%h ill=%b stall=%0d required all 0",
               in_ready, wb_valid, wb_data, illegal, stall_cnt);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [3:0] r; logic [DW-1:0] d; logic [DW-1:0] exp;
    logic [15:0] exp_stall;
    send(4'd9, 4'd1, 4'd0, 4'd0, 16'd5);
    send(4'd9, 4'd2, 4'd0, 4'd0, 16'd3);
    exec(4'd1, 4'd3, 4'd1, 4'd2, 16'd0, v, r, d);
    exp = {4{16'd8}};
    checks++;
    if (v !== 1'b1 || r !== 4'd3 || d !== exp) begin
      errors++; $display("FAIL b2b_vadd v=%b rd=%0d data=%h required 1/3/%h", v, r, d, exp);
    end
`ifdef SIMD_VEC_FWD_EN
    exp_stall = 16'd0;
`else
    // r2 sits in E when VADD is presented: one bubble, then W write-through serves it
    exp_stall = 16'd1;
`endif
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL b2b_stall_cnt got=%0d required %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_arith();
    logic v; logic [3:0] r; logic [DW-1:0] d; logic [DW-1:0] exp;
    exec(4'd9, 4'd1, 4'd0, 4'd0, 16'hFFFF, v, r, d);
    exec(4'd10, 4'd4, 4'd1, 4'd0, 16'd2, v, r, d);
    exp = {4{16'h0001}};
    checks++;
    if (v !== 1'b1 || d !== exp) begin
      errors++; $display("FAIL vaddi_wrap data=%h required %h", d, exp);
    end
    exec(4'd3, 4'd5, 4'd1, 4'd1, 16'd0, v, r, d);
    checks++;
    if (d !== exp || r !== 4'd5) begin
      errors++; $display("FAIL vmul_low data=%h rd=%0d required %h/5", d, r, exp);
    end
    exec(4'd2, 4'd10, 4'd0, 4'd1, 16'd0, v, r, d);
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vsub data=%h required %h", d, exp);
    end
    exec(4'd9, 4'd11, 4'd0, 4'd0, 16'h0F0F, v, r, d);
    exec(4'd9, 4'd12, 4'd0, 4'd0, 16'h00FF, v, r, d);
    exec(4'd4, 4'd13, 4'd11, 4'd12, 16'd0, v, r, d);
    exp = {4{16'h000F}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vand data=%h required %h", d, exp);
    end
    exec(4'd5, 4'd13, 4'd11, 4'd12, 16'd0, v, r, d);
    exp = {4{16'h0FFF}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vor data=%h required %h", d, exp);
    end
    exec(4'd6, 4'd13, 4'd11, 4'd12, 16'd0, v, r, d);
    exp = {4{16'h0FF0}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vxor data=%h required %h", d, exp);
    end
  endtask

  task automatic test_shift();
    logic v; logic [3:0] r; logic [DW-1:0] d; logic [DW-1:0] exp;
    exec(4'd9, 4'd6, 4'd0, 4'd0, 16'h8001, v, r, d);
    exec(4'd7, 4'd7, 4'd6, 4'd0, 16'd1, v, r, d);
    exp = {4{16'h0002}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vshl data=%h required %h", d, exp);
    end
    exec(4'd8, 4'd8, 4'd6, 4'd0, 16'd15, v, r, d);
    exp = {4{16'h0001}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL vshr data=%h required %h", d, exp);
    end
  endtask

  task automatic test_illegal();
    logic v; logic [3:0] r; logic [DW-1:0] d; logic [DW-1:0] exp;
    exec(4'd12, 4'd3, 4'd1, 4'd2, 16'hFFFF, v, r, d);
    checks++;
    if (v !== 1'b1 || d !== '0 || illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_op v=%b data=%h ill=%b required 1/0/1", v, d, illegal);
    end
    exec(4'd5, 4'd14, 4'd3, 4'd3, 16'd0, v, r, d);
    exp = {4{16'd8}};
    checks++;
    if (d !== exp || illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_no_write r3=%h ill=%b required %h/1", d, illegal, exp);
    end
  endtask

  task automatic test_flush();
    logic v; logic [3:0] r; logic [DW-1:0] d; logic [DW-1:0] exp;
    exec(4'd9, 4'd9, 4'd0, 4'd0, 16'd7, v, r, d);
    send(4'd9, 4'd9, 4'd0, 4'd0, 16'd9);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd9; in_rd = 4'd9; in_imm = 16'd11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready got=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_kill_e wb_valid=%b required 0", wb_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop_accept wb_valid=%b required 0", wb_valid);
    end
    exec(4'd5, 4'd14, 4'd9, 4'd9, 16'd0, v, r, d);
    exp = {4{16'd7}};
    checks++;
    if (d !== exp) begin
      errors++; $display("FAIL flush_r9 data=%h required %h", d, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic v; logic [3:0] r; logic [DW-1:0] d;
    send(4'd9, 4'd1, 4'd0, 4'd0, 16'h1234);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b0 || wb_data !== '0 || illegal !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL midreset_outputs rdy=%b wbv=%b data=%h ill=%b stall=%0d required all 0",
               in_ready, wb_valid, wb_data, illegal, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    exec(4'd1, 4'd0, 4'd0, 4'd0, 16'd0, v, r, d);
    checks++;
    if (v !== 1'b1 || d !== '0) begin
      errors++; $display("FAIL midreset_vadd v=%b data=%h required 1/0", v, d);
    end
    exec(4'd5, 4'd14, 4'd1, 4'd1, 16'd0, v, r, d);
    checks++;
    if (d !== '0) begin
      errors++; $display("FAIL midreset_r1_cleared data=%h required 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_arith();
    test_shift();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
